pipelined_shifter: RTL and testbench
====================================

Name: pipelined_shifter

Overview:
- Parametrised, pipelined shift/rotate unit for the execute stage. Successor to the 16-bit combinational shifter.
- Generalised to N-bit data and a 3-bit op with an added rotate right.
- Splits the log2(N) mux levels across PIPE register stages, with a valid/ready handshake and output backpressure.

Parameters:
- N, 16, data width; must equal 2**C.
- C, 4, shift-count width; levels shift by 2^0 .. 2^(C-1).
- PIPE, 2, number of register stages; legal range 1..C.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request this cycle.
- in_data  input  N  operand.
- in_cnt  input  C  shift amount, 0..N-1.
- in_op  input  3  operation select:
  - 000 rotate left
  - 001 shift left logical
  - 010 shift right arithmetic
  - 011 shift right logical
  - 100 rotate right
  - 101-111 reserved
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  N  result.
- out_err  output  1  result came from a reserved op.

Behaviour:
- Reset: asynchronous, active-low (rst_n=0), applied immediately, not at the next edge.
  - All stage valid bits, out_valid, out_data, out_err and flags go to 0.
  - Any in-flight operations are discarded with no partial output.
- Accept: a request is taken on a rising edge when in_valid && in_ready.
- Stall: stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - Every pipeline register loads only when !stall; otherwise all stages hold data, count, op and valid.
  - Bubbles are not compressed.
- Latency: exactly PIPE cycles from accept to out_valid, absent stalls. Throughput is 1 op/cycle.
- Level mapping: level i (shift by 2^i when cnt[i]=1) is computed combinationally in stage floor(i*PIPE/C).
  - The stage's register captures data after its last level.
  - The count and op travel with the data.
- Fill rules:
  - SLL and SRL fill with 0.
  - SRA fills with the original in_data[N-1], carried down the pipe.
  - Rotates wrap bits around.
- cnt=0: out_data = in_data for all legal ops.
- Reserved op: out_data = 0 and out_err = 1, still with PIPE latency and a normal handshake. out_err = 0 for legal ops.
- Output hold: out_data and out_err stay stable while out_valid && !out_ready.
- Simultaneous events: accept and output consume in the same cycle is legal. The pipe advances and no result is lost or duplicated.
- Ordering: results always leave in acceptance order.
- Dropped cycles: in_valid with in_ready=0 does not accept; the requester holds the request.

Optional Feature:
- Macro: SHIFT_FLAGS_EN.
- When defined, add output ports out_carry (1) and out_zero (1), registered alongside out_data. Both reset to 0.
- out_zero = (out_data == 0).
- out_carry by op, with cnt != 0:
  - SLL: in_data[N-cnt].
  - SRA/SRL: in_data[cnt-1].
  - ROL: out_data[0].
  - ROR: out_data[N-1].
- out_carry = 0 when cnt == 0 or the op is reserved.
- When not defined, these ports and their logic do not exist.

Test Plan:
- Defaults (N=16, PIPE=2):
  - ROL 0x8001 cnt1 -> 0x0003 two cycles after accept (carry 1).
  - ROR 0x0001 cnt1 -> 0x8000 (carry 1).
  - SLL 0x00FF cnt4 -> 0x0FF0 (carry 0).
- SRA 0x8000 cnt15 -> 0xFFFF (carry 0); SRL 0x8000 cnt15 -> 0x0001 (carry 0); SRL 0x1234 cnt0 -> 0x1234 (carry 0, zero 0).
- Four back-to-back requests, out_ready low for 3 cycles after the first result:
  - in_ready drops the same cycle out_valid && !out_ready.
  - out_data is held stable.
  - All four results appear in order, with none lost or duplicated.
- Reserved op 101 on 0xFFFF cnt3 -> out_data 0x0000, out_err 1 at latency 2. A following legal op gives out_err 0.
- Assert rst_n mid-flight with two ops in the pipe: out_valid, out_data and flags go to 0 asynchronously, and no stale result appears after release.
- Sweep PIPE=1 and PIPE=4 with random data, op and cnt against a reference model. Check that latency equals PIPE and results match bit-exactly.

Source files
------------

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: N-bit shift/rotate unit whose log2(N) mux levels are
// spread over PIPE register stages, with valid/ready flow control on both
// sides and whole-pipe stall on output backpressure.
// Optional carry/zero flag outputs are built when SHIFT_FLAGS_EN is defined.
module pipelined_shifter #(
  parameter int N    = 16,
  parameter int C    = 4,
  parameter int PIPE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [C-1:0] in_cnt,
  input  logic [2:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
`ifdef SHIFT_FLAGS_EN
  output logic         out_carry,
  output logic         out_zero,
`endif
  output logic         out_err
);

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // Ops above ROR are reserved encodings.
  function automatic logic f_is_reserved(input logic [2:0] op);
    return (op > OP_ROR);
  endfunction

  // One mux level: shift/rotate by 2^lvl. SRA fills with the carried sign.
  function automatic logic [N-1:0] f_level(input logic [N-1:0] d,
                                           input logic [2:0]   op,
                                           input logic         sign,
                                           input int           lvl);
    logic [N-1:0] fill;
    int           amt;
    amt  = 32'sd1 << lvl;
    fill = {N{sign}};
    case (op)
      OP_ROL:  f_level = (d << amt) | (d >> (N - amt));
      OP_SLL:  f_level = d << amt;
      OP_SRA:  f_level = (d >> amt) | (fill << (N - amt));
      OP_SRL:  f_level = d >> amt;
      OP_ROR:  f_level = (d >> amt) | (d << (N - amt));
      default: f_level = d;
    endcase
  endfunction

  // Stage registers; index PIPE-1 is the output stage.
  logic [N-1:0]    r_data [PIPE];
  logic [C-1:0]    r_cnt  [PIPE];
  logic [2:0]      r_op   [PIPE];
  logic            r_sign [PIPE];
  logic [PIPE-1:0] r_vld;
  logic            r_err;

  // Values presented to each stage's combinational levels.
  logic [N-1:0]    w_src_data [PIPE];
  logic [C-1:0]    w_src_cnt  [PIPE];
  logic [2:0]      w_src_op   [PIPE];
  logic            w_src_sign [PIPE];
  logic [PIPE-1:0] w_src_vld;
  logic [N-1:0]    w_nxt_data [PIPE];
  logic [N-1:0]    w_last_data;
  logic            w_last_err;
  logic            w_stall;

`ifdef SHIFT_FLAGS_EN
  logic            r_cy [PIPE];
  logic            r_zero;
  logic            w_src_cy [PIPE];
  logic            w_cy0;
  logic [C-1:0]    w_idx_hi;
  logic [C-1:0]    w_idx_lo;
`endif

  assign w_stall   = r_vld[PIPE-1] && !out_ready;
  assign in_ready  = !w_stall;
  assign out_valid = r_vld[PIPE-1];
  assign out_data  = r_data[PIPE-1];
  assign out_err   = r_err;

  // Route the request into stage 0 and each register into the next stage.
  always_comb begin
    w_src_data[0] = in_data;
    w_src_cnt[0]  = in_cnt;
    w_src_op[0]   = in_op;
    w_src_sign[0] = in_data[N-1];
    w_src_vld[0]  = in_valid;
    for (int s = 1; s < PIPE; s++) begin
      w_src_data[s] = r_data[s-1];
      w_src_cnt[s]  = r_cnt[s-1];
      w_src_op[s]   = r_op[s-1];
      w_src_sign[s] = r_sign[s-1];
      w_src_vld[s]  = r_vld[s-1];
    end
  end

  // Apply the levels owned by each stage (level i lives in stage i*PIPE/C).
  always_comb begin
    for (int s = 0; s < PIPE; s++) begin
      w_nxt_data[s] = w_src_data[s];
      for (int i = 0; i < C; i++) begin
        if ((((i * PIPE) / C) == s) && w_src_cnt[s][i]) begin
          w_nxt_data[s] = f_level(w_nxt_data[s], w_src_op[s], w_src_sign[s], i);
        end else begin
          w_nxt_data[s] = w_nxt_data[s];
        end
      end
    end
  end

  // Final stage forces reserved ops to a zero result with the error flag.
  always_comb begin
    w_last_err = f_is_reserved(w_src_op[PIPE-1]);
    if (w_last_err) begin
      w_last_data = {N{1'b0}};
    end else begin
      w_last_data = w_nxt_data[PIPE-1];
    end
  end

`ifdef SHIFT_FLAGS_EN
  // Carry is the last bit shifted/rotated out; it only depends on the
  // original operand, so it is resolved at entry and travels with the op.
  always_comb begin
    w_idx_hi = {C{1'b0}} - in_cnt;
    w_idx_lo = in_cnt - {{(C-1){1'b0}}, 1'b1};
    w_cy0    = 1'b0;
    if (in_cnt == {C{1'b0}}) begin
      w_cy0 = 1'b0;
    end else begin
      case (in_op)
        OP_ROL, OP_SLL:         w_cy0 = in_data[w_idx_hi];
        OP_SRA, OP_SRL, OP_ROR: w_cy0 = in_data[w_idx_lo];
        default:                w_cy0 = 1'b0;
      endcase
    end
  end

  // Carry follows its op down the pipe.
  always_comb begin
    w_src_cy[0] = w_cy0;
    for (int s = 1; s < PIPE; s++) begin
      w_src_cy[s] = r_cy[s-1];
    end
  end

  // Flag registers advance in lockstep with the data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < PIPE; s++) begin
        r_cy[s] <= 1'b0;
      end
      r_zero <= 1'b0;
    end else if (!w_stall) begin
      for (int s = 0; s < PIPE; s++) begin
        r_cy[s] <= w_src_cy[s];
      end
      r_zero <= (w_last_data == {N{1'b0}});
    end
  end

  assign out_carry = r_cy[PIPE-1];
  assign out_zero  = r_zero;
`endif

  // Pipeline registers: all stages advance together unless the output stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < PIPE; s++) begin
        r_data[s] <= {N{1'b0}};
        r_cnt[s]  <= {C{1'b0}};
        r_op[s]   <= 3'b000;
        r_sign[s] <= 1'b0;
      end
      r_vld <= {PIPE{1'b0}};
      r_err <= 1'b0;
    end else if (!w_stall) begin
      for (int s = 0; s < PIPE; s++) begin
        r_data[s] <= (s == PIPE - 1) ? w_last_data : w_nxt_data[s];
        r_cnt[s]  <= w_src_cnt[s];
        r_op[s]   <= w_src_op[s];
        r_sign[s] <= w_src_sign[s];
      end
      r_vld <= w_src_vld;
      r_err <= w_last_err;
    end
  end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed and randomised checks of pipelined_shifter at PIPE=2, 1 and 4.
// Flag outputs are checked when SHIFT_FLAGS_EN is defined.
module tb_pipelined_shifter;
  localparam int N = 16;
  localparam int C = 4;

  typedef struct packed {
    logic [2:0]   op;
    logic [N-1:0] d;
    logic [C-1:0] cnt;
    logic [N-1:0] exp;
    logic         err;
    logic         cy;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_err;
  logic [N-1:0] a_in_data, a_out_data, b_in_data, b_out_data, c_in_data, c_out_data;
  logic [C-1:0] a_in_cnt, b_in_cnt, c_in_cnt;
  logic [2:0]   a_in_op, b_in_op, c_in_op;
`ifdef SHIFT_FLAGS_EN
  logic a_out_carry, a_out_zero, b_out_carry, b_out_zero, c_out_carry, c_out_zero;
`endif

  vec_t         vecs [10];
  logic [N-1:0] bp_exp [4];
  logic [N+1:0] qb_exp [$];
  logic [N+1:0] qc_exp [$];
  int           qb_t [$];
  int           qc_t [$];
  logic [N+1:0] e;
  int           t;
  int           n_in, n_out, low_left;
  logic         seen, acc, con;

  pipelined_shifter #(.N(N), .C(C), .PIPE(2)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_cnt(a_in_cnt), .in_op(a_in_op),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
`ifdef SHIFT_FLAGS_EN
    .out_carry(a_out_carry), .out_zero(a_out_zero),
`endif
    .out_err(a_out_err)
  );

  pipelined_shifter #(.N(N), .C(C), .PIPE(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_cnt(b_in_cnt), .in_op(b_in_op),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
`ifdef SHIFT_FLAGS_EN
    .out_carry(b_out_carry), .out_zero(b_out_zero),
`endif
    .out_err(b_out_err)
  );

  pipelined_shifter #(.N(N), .C(C), .PIPE(4)) u_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .in_cnt(c_in_cnt), .in_op(c_in_op),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
`ifdef SHIFT_FLAGS_EN
    .out_carry(c_out_carry), .out_zero(c_out_zero),
`endif
    .out_err(c_out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit-by-bit reference: returns {carry, err, data}.
  function automatic logic [N+1:0] ref_op(input logic [N-1:0] d, input logic [C-1:0] cnt,
                                          input logic [2:0] op);
    logic [N-1:0] r;
    logic         cy;
    logic         er;
    int           k;
    r  = {N{1'b0}};
    cy = 1'b0;
    k  = int'(cnt);
    er = (op > 3'b100);
    for (int j = 0; j < N; j++) begin
      case (op)
        3'b000: r[(j + k) % N] = d[j];
        3'b001: if (j >= k) r[j] = d[j - k]; else r[j] = 1'b0;
        3'b010: if (j + k < N) r[j] = d[j + k]; else r[j] = d[N-1];
        3'b011: if (j + k < N) r[j] = d[j + k]; else r[j] = 1'b0;
        3'b100: r[j] = d[(j + k) % N];
        default: r[j] = 1'b0;
      endcase
    end
    if (k != 0) begin
      case (op)
        3'b001:         cy = d[N - k];
        3'b010, 3'b011: cy = d[k - 1];
        3'b000:         cy = r[0];
        3'b100:         cy = r[N-1];
        default:        cy = 1'b0;
      endcase
    end
    return {cy, er, r};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    failures = 0;
    vecs[0] = {3'b000, 16'h8001, 4'd1,  16'h0003, 1'b0, 1'b1};
    vecs[1] = {3'b100, 16'h0001, 4'd1,  16'h8000, 1'b0, 1'b1};
    vecs[2] = {3'b001, 16'h00FF, 4'd4,  16'h0FF0, 1'b0, 1'b0};
    vecs[3] = {3'b010, 16'h8000, 4'd15, 16'hFFFF, 1'b0, 1'b0};
    vecs[4] = {3'b011, 16'h8000, 4'd15, 16'h0001, 1'b0, 1'b0};
    vecs[5] = {3'b011, 16'h1234, 4'd0,  16'h1234, 1'b0, 1'b0};
    vecs[6] = {3'b101, 16'hFFFF, 4'd3,  16'h0000, 1'b1, 1'b0};
    vecs[7] = {3'b000, 16'h1234, 4'd4,  16'h2341, 1'b0, 1'b1};
    vecs[8] = {3'b010, 16'h7000, 4'd4,  16'h0700, 1'b0, 1'b0};
    vecs[9] = {3'b100, 16'h00F1, 4'd4,  16'h100F, 1'b0, 1'b0};
    bp_exp[0] = 16'h0002; bp_exp[1] = 16'h0004; bp_exp[2] = 16'h0006; bp_exp[3] = 16'h0008;

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = 16'h0000; a_in_cnt = 4'd0; a_in_op = 3'b000; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = 16'h0000; b_in_cnt = 4'd0; b_in_op = 3'b000; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = 16'h0000; c_in_cnt = 4'd0; c_in_op = 3'b000; c_out_ready = 1'b1;
    #12;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_out_err", a_out_err, 0);
    chk("rst_in_ready", a_in_ready, 1);
`ifdef SHIFT_FLAGS_EN
    chk("rst_carry", a_out_carry, 0);
    chk("rst_zero", a_out_zero, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed vectors, one at a time, latency PIPE=2.
    for (int i = 0; i < 10; i++) begin
      a_in_op = vecs[i].op; a_in_data = vecs[i].d; a_in_cnt = vecs[i].cnt; a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      chk($sformatf("v%0d_early_valid", i), a_out_valid, 0);
      tick();
      chk($sformatf("v%0d_valid", i), a_out_valid, 1);
      chk($sformatf("v%0d_data", i), a_out_data, vecs[i].exp);
      chk($sformatf("v%0d_err", i), a_out_err, vecs[i].err);
`ifdef SHIFT_FLAGS_EN
      chk($sformatf("v%0d_carry", i), a_out_carry, vecs[i].cy);
      chk($sformatf("v%0d_zero", i), a_out_zero, (vecs[i].exp == 16'h0000));
`endif
    end
    tick();

    // Four back-to-back requests with a 3-cycle output stall.
    n_in = 0; n_out = 0; low_left = 0; seen = 1'b0;
    a_in_op = 3'b001; a_in_cnt = 4'd1; a_in_data = 16'h0001; a_in_valid = 1'b1;
    for (int cyc = 0; cyc < 30 && n_out < 4; cyc++) begin
      if (a_out_valid && !seen) begin
        seen = 1'b1;
        low_left = 3;
      end
      a_out_ready = (low_left == 0);
      #1;
      if (!a_out_ready) begin
        chk("bp_in_ready", a_in_ready, 0);
        chk("bp_hold_data", a_out_data, bp_exp[n_out]);
      end
      acc = a_in_valid && a_in_ready;
      con = a_out_valid && a_out_ready;
      if (con) begin
        chk($sformatf("bp_order%0d", n_out), a_out_data, bp_exp[n_out]);
        n_out++;
      end
      if (low_left > 0) low_left--;
      tick();
      if (acc) begin
        n_in++;
        if (n_in < 4) a_in_data = 16'(n_in + 1);
        else a_in_valid = 1'b0;
      end
    end
    chk("bp_count", n_out, 4);
    chk("bp_drained", a_out_valid, 0);
    tick();
    chk("bp_no_dup", a_out_valid, 0);

    // Asynchronous reset with two ops in flight.
    a_out_ready = 1'b1;
    a_in_op = 3'b001; a_in_data = 16'h00FF; a_in_cnt = 4'd4; a_in_valid = 1'b1;
    tick();
    a_in_op = 3'b000; a_in_data = 16'h8001; a_in_cnt = 4'd1;
    tick();
    a_in_valid = 1'b0;
    chk("mid_pre_valid", a_out_valid, 1);
    chk("mid_pre_data", a_out_data, 16'h0FF0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", a_out_valid, 0);
    chk("mid_rst_data", a_out_data, 0);
    chk("mid_rst_err", a_out_err, 0);
`ifdef SHIFT_FLAGS_EN
    chk("mid_rst_carry", a_out_carry, 0);
    chk("mid_rst_zero", a_out_zero, 0);
`endif
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("mid_stale%0d", i), a_out_valid, 0);
    end

    // Random sweep against the reference at PIPE=1 and PIPE=4.
    for (int cyc = 0; cyc < 70; cyc++) begin
      if (b_out_valid) begin
        if (qb_exp.size() == 0) begin
          chk("b_extra", b_out_valid, 0);
        end else begin
          e = qb_exp.pop_front();
          t = qb_t.pop_front();
          chk("b_data", b_out_data, e[N-1:0]);
          chk("b_err", b_out_err, e[N]);
          chk("b_lat", cyc - t, 1);
`ifdef SHIFT_FLAGS_EN
          chk("b_carry", b_out_carry, e[N+1]);
          chk("b_zero", b_out_zero, (e[N-1:0] == 16'h0000));
`endif
        end
      end
      if (c_out_valid) begin
        if (qc_exp.size() == 0) begin
          chk("c_extra", c_out_valid, 0);
        end else begin
          e = qc_exp.pop_front();
          t = qc_t.pop_front();
          chk("c_data", c_out_data, e[N-1:0]);
          chk("c_err", c_out_err, e[N]);
          chk("c_lat", cyc - t, 4);
`ifdef SHIFT_FLAGS_EN
          chk("c_carry", c_out_carry, e[N+1]);
          chk("c_zero", c_out_zero, (e[N-1:0] == 16'h0000));
`endif
        end
      end
      if (cyc < 56) begin
        b_in_valid = ($urandom_range(0, 3) != 0);
        b_in_data  = 16'($urandom);
        b_in_cnt   = 4'($urandom_range(0, 15));
        b_in_op    = 3'($urandom_range(0, 7));
      end else begin
        b_in_valid = 1'b0;
      end
      c_in_valid = b_in_valid; c_in_data = b_in_data; c_in_cnt = b_in_cnt; c_in_op = b_in_op;
      #1;
      if (b_in_valid && b_in_ready) begin
        qb_exp.push_back(ref_op(b_in_data, b_in_cnt, b_in_op));
        qb_t.push_back(cyc);
      end
      if (c_in_valid && c_in_ready) begin
        qc_exp.push_back(ref_op(c_in_data, c_in_cnt, c_in_op));
        qc_t.push_back(cyc);
      end
      tick();
    end
    chk("b_drain", qb_exp.size(), 0);
    chk("c_drain", qc_exp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
